// File: rtl/lfa_mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams W-bit word pairs LSW first through a
// Ladner-Fischer prefix adder with chained carry. Optional signed overflow: LFA_MP_SIGNED_OVF_EN.
module lfa_mp_add_seq #(
    parameter int W         = 24,
    parameter int MAX_WORDS = 16,
    parameter int CW        = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  IN_X,
    input  logic [W-1:0]  IN_Y,
    input  logic          IN_SUB,
    input  logic          IN_LAST,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [W-1:0]  OUT_S,
    output logic [CW-1:0] OUT_IDX,
    output logic          OUT_LAST,
    output logic          OUT_CARRY,
    output logic          OUT_ERR
`ifdef LFA_MP_SIGNED_OVF_EN
    ,
    output logic          OUT_OVF
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] idx, idx_n, cur_idx;
    logic          carry_reg, carry_n, sub_reg, sub_n;
    logic          accept, first, sub_eff, cin, forced, last_w;
    logic [W-1:0]  yeff;
    logic [W:0]    result;

    // Sklansky-style Ladner-Fischer prefix adder; carry-in folded into bit 0's generate.
    function automatic logic [W:0] lf_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci);
        logic [W-1:0] g, p, gl, pl, gn, pn;
        int j;
        g  = a & b;
        p  = a ^ b;
        gl = g;
        gl[0] = g[0] | (p[0] & ci);
        pl = p;
        for (int l = 0; (1 << l) < W; l++) begin
            gn = gl;
            pn = pl;
            for (int i = 0; i < W; i++) begin
                if (((i >> l) & 1) != 0) begin
                    j = ((i >> l) << l) - 1;
                    gn[i] = gl[i] | (pl[i] & gl[j]);
                    pn[i] = pl[i] & pl[j];
                end
            end
            gl = gn;
            pl = pn;
        end
        return {gl[W-1], p ^ {gl[W-2:0], ci}};
    endfunction

    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;

    // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
    always_comb begin
        first   = (state == IDLE);
        sub_eff = first ? IN_SUB : sub_reg;
        cin     = first ? IN_SUB : carry_reg;
        yeff    = sub_eff ? ~IN_Y : IN_Y;
        result  = lf_add(IN_X, yeff, cin);
        cur_idx = first ? '0 : idx;
        forced  = !first && (idx == CW'(MAX_WORDS - 1)) && !IN_LAST;
        last_w  = IN_LAST || forced;

        state_n = state;
        idx_n   = idx;
        carry_n = carry_reg;
        sub_n   = sub_reg;
        if (accept) begin
            carry_n = result[W];
            sub_n   = sub_eff;
            if (last_w) begin
                state_n = IDLE;
                idx_n   = '0;
            end else begin
                state_n = BUSY;
                idx_n   = cur_idx + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            carry_reg <= carry_n;
            sub_reg   <= sub_n;
        end
    end

    // Output register loads on every accept and holds while stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_S     <= '0;
            OUT_IDX   <= '0;
            OUT_LAST  <= 1'b0;
            OUT_CARRY <= 1'b0;
            OUT_ERR   <= 1'b0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            OUT_S     <= result[W-1:0];
            OUT_IDX   <= cur_idx;
            OUT_LAST  <= last_w;
            OUT_CARRY <= last_w & result[W];
            OUT_ERR   <= forced;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef LFA_MP_SIGNED_OVF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_OVF <= 1'b0;
        end else if (accept) begin
            OUT_OVF <= last_w && (IN_X[W-1] == yeff[W-1]) && (result[W-1] != IN_X[W-1]);
        end
    end
`endif

endmodule
